// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: hazard-unit stall bit indices, bubble payload
// and the skid-stage state encoding.
package cpu_pipe_pkg;

  localparam int STALL_BIT_IF  = 0;
  localparam int STALL_BIT_ID  = 1;
  localparam int STALL_BIT_EX  = 2;
  localparam int STALL_BIT_MEM = 3;
  localparam int STALL_BIT_WB  = 4;

  localparam int OP_W     = 6;
  localparam int STATUS_W = 1;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int PAYLOAD_W_DFLT = OP_W + STATUS_W + ADDR_W + DATA_W + REG_W;

  // Register address 0 doubles as "no destination register".
  localparam logic [REG_W-1:0] NOP_REG_ADDR = 5'd0;

  localparam logic [PAYLOAD_W_DFLT-1:0] NOP_PAYLOAD_DFLT =
    {6'd0, 1'b0, 32'd0, 32'd0, NOP_REG_ADDR};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_stage.sv
// Pipeline register stage with optional two-entry skid buffer, hazard-unit
// stall and flush. Outputs come straight from registers.
module pipe_skid_stage
  import cpu_pipe_pkg::*;
#(
  parameter int PAYLOAD_W = PAYLOAD_W_DFLT,
  parameter int STALL_W   = 6,
  parameter int STALL_BIT = STALL_BIT_MEM,
  parameter int SKID_EN   = 1,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = PAYLOAD_W'(NOP_PAYLOAD_DFLT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall_in,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [1:0]           occupancy
);

  skid_state_e          state_r;
  logic [PAYLOAD_W-1:0] main_r;
  logic [PAYLOAD_W-1:0] skid_r;
  logic                 out_valid_r;
  logic [1:0]           occupancy_r;

  logic stall_s;
  logic in_ready_s;
  logic accept_s;
  logic emit_s;
  logic stall_unused_s;

  assign stall_s        = stall_in[STALL_BIT];
  assign stall_unused_s = ^stall_in;

  // Upstream ready: the skid variant ignores out_ready so the path stays short.
  always_comb begin
    in_ready_s = 1'b0;
    if (rst || stall_s) begin
      in_ready_s = 1'b0;
    end else if (SKID_EN != 0) begin
      in_ready_s = (state_r != TWO);
    end else begin
      in_ready_s = !out_valid_r || out_ready;
    end
  end

  assign accept_s = in_valid && in_ready_s;
  assign emit_s   = out_valid_r && out_ready && !stall_s;

  // Stage FSM; flush clears everything, including an entry accepted this cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_r     <= EMPTY;
      main_r      <= NOP_PAYLOAD;
      skid_r      <= NOP_PAYLOAD;
      out_valid_r <= 1'b0;
      occupancy_r <= 2'd0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_r     <= ONE;
            main_r      <= in_payload;
            out_valid_r <= 1'b1;
            occupancy_r <= 2'd1;
          end
        end
        ONE: begin
          if (accept_s && emit_s) begin
            main_r <= in_payload;
          end else if (accept_s && (SKID_EN != 0)) begin
            state_r     <= TWO;
            skid_r      <= in_payload;
            occupancy_r <= 2'd2;
          end else if (emit_s) begin
            state_r     <= EMPTY;
            main_r      <= NOP_PAYLOAD;
            out_valid_r <= 1'b0;
            occupancy_r <= 2'd0;
          end
        end
        TWO: begin
          if (emit_s) begin
            state_r     <= ONE;
            main_r      <= skid_r;
            skid_r      <= NOP_PAYLOAD;
            occupancy_r <= 2'd1;
          end
        end
        default: begin
          state_r     <= EMPTY;
          main_r      <= NOP_PAYLOAD;
          skid_r      <= NOP_PAYLOAD;
          out_valid_r <= 1'b0;
          occupancy_r <= 2'd0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_r;
  assign out_payload = main_r;
  assign occupancy   = occupancy_r;

endmodule
